// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, limits and divisor clamp for the clock divider bank
package clk_div_pkg;

  localparam int unsigned DIV_MIN  = 2;
  // Channel state is held at a fixed width; narrower DIVW builds leave the top bits at zero.
  localparam int unsigned DIV_WMAX = 16;

  typedef logic [DIV_WMAX-1:0] div_t;

  typedef struct packed {
    div_t cnt;
    div_t d;
    div_t p;
    logic pending;
  } chan_state_t;

  function automatic div_t clamp_div(input div_t v);
    return (v < div_t'(DIV_MIN)) ? div_t'(DIV_MIN) : v;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, pending reload and output decode
// CLK_DIV_LOCK_EN adds the apply_o port used by the bank's settle counter.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIVW      = 8,
  parameter int DIV_RESET = 2
) (
  input  logic            clkin,
  input  logic            reset,
`ifdef CLK_DIV_LOCK_EN
  output logic            apply_o,
`endif
  input  logic [DIVW-1:0] div_val_i,
  input  logic            div_load_i,
  input  logic            sync_i,
  output logic            div_busy_o,
  output logic            clk_out_o,
  output logic            clk_en_o
);

  chan_state_t st_q, st_d;
  logic        clk_out_q, clk_out_d;
  logic        clk_en_q, clk_en_d;
  logic        boundary;
  logic        pend_eff;
  logic        apply;
  div_t        p_eff;

  always_comb begin
    st_d      = st_q;
    boundary  = (st_q.cnt == (st_q.d - div_t'(1)));
    // A load landing on the wrap or on sync is folded in so it applies at that edge.
    pend_eff  = st_q.pending | div_load_i;
    p_eff     = div_load_i ? clamp_div(div_t'(div_val_i)) : st_q.p;
    apply     = (sync_i | boundary) & pend_eff;
    clk_out_d = (st_q.cnt < (st_q.d >> 1));
    clk_en_d  = boundary;

    st_d.p       = p_eff;
    st_d.pending = pend_eff;
    if (sync_i || boundary) begin
      st_d.cnt = '0;
      if (pend_eff) begin
        st_d.d       = p_eff;
        st_d.pending = 1'b0;
      end
    end else begin
      st_d.cnt = st_q.cnt + div_t'(1);
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      st_q.cnt     <= '0;
      st_q.d       <= div_t'(DIV_RESET);
      st_q.p       <= '0;
      st_q.pending <= 1'b0;
      clk_out_q    <= 1'b0;
      clk_en_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
    end
  end

`ifdef CLK_DIV_LOCK_EN
  assign apply_o = apply;
`endif
  assign div_busy_o = st_q.pending;
  assign clk_out_o  = clk_out_q;
  assign clk_en_o   = clk_en_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel programmable clock-enable / divided-clock generator
// CLK_DIV_LOCK_EN enables the settle counter behind lock; otherwise lock rises right after reset.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int DIVW        = 8,
  parameter int DIV_RESET   = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [NCH*DIVW-1:0] div_val,
  input  logic [NCH-1:0]      div_load,
  input  logic                sync,
  output logic [NCH-1:0]      div_busy,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      clk_en,
  output logic                lock
);

  if (NCH < 1 || NCH > 8 || DIVW < 2 || DIVW > int'(DIV_WMAX) ||
      DIV_RESET < int'(DIV_MIN) || DIV_RESET >= (1 << DIVW) ||
      LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_param_check
    $error("clk_div_bank: parameter out of range");
  end

  logic lock_q, lock_d;

`ifdef CLK_DIV_LOCK_EN
  logic [NCH-1:0] apply;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .DIVW      (DIVW),
      .DIV_RESET (DIV_RESET)
    ) u_chan (
      .clkin      (clkin),
      .reset      (reset),
`ifdef CLK_DIV_LOCK_EN
      .apply_o    (apply[i]),
`endif
      .div_val_i  (div_val[i*DIVW +: DIVW]),
      .div_load_i (div_load[i]),
      .sync_i     (sync),
      .div_busy_o (div_busy[i]),
      .clk_out_o  (clk_out[i]),
      .clk_en_o   (clk_en[i])
    );
  end

`ifdef CLK_DIV_LOCK_EN
  localparam logic [15:0] SETTLE_MAX = 16'(LOCK_CYCLES - 1);

  logic [15:0] settle_q, settle_d;
  logic        restart;

  // Saturating settle count; lock goes high on the edge after it reaches its limit.
  always_comb begin
    restart  = sync | (|apply);
    settle_d = settle_q;
    lock_d   = 1'b0;
    if (restart) begin
      settle_d = '0;
    end else begin
      if (settle_q != SETTLE_MAX) settle_d = settle_q + 16'd1;
      lock_d = (settle_q == SETTLE_MAX);
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) settle_q <= '0;
    else       settle_q <= settle_d;
  end
`else
  always_comb lock_d = 1'b1;
`endif

  always_ff @(posedge clkin) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  assign lock = lock_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - randomized and directed self-checking bench for clk_div_bank
module tb_clk_div_bank;

  localparam int NCH         = 2;
  localparam int DIVW        = 8;
  localparam int DIV_RESET   = 4;
  localparam int LOCK_CYCLES = 16;

  logic                clkin = 1'b0;
  logic                reset = 1'b1;
  logic [NCH*DIVW-1:0] div_val = '0;
  logic [NCH-1:0]      div_load = '0;
  logic                sync = 1'b0;
  logic [NCH-1:0]      div_busy, clk_out, clk_en;
  logic                lock;

  clk_div_bank #(
    .NCH(NCH), .DIVW(DIVW), .DIV_RESET(DIV_RESET), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clkin(clkin), .reset(reset), .div_val(div_val), .div_load(div_load), .sync(sync),
    .div_busy(div_busy), .clk_out(clk_out), .clk_en(clk_en), .lock(lock)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference: each channel's phase is (cycles since its last restart) mod divisor.
  int             m_t0[NCH];
  int             m_d[NCH];
  int             m_p[NCH];
  bit             m_pend[NCH];
  int             m_ls;
  logic [NCH-1:0] e_out, e_en, e_busy;
  logic           e_lock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int mpos(input int ch);
    return (cyc - m_t0[ch]) % m_d[ch];
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_t0[ch] = 0; m_d[ch] = DIV_RESET; m_p[ch] = 0; m_pend[ch] = 0;
    end
    m_ls = 0; e_out = '0; e_en = '0; e_busy = '0; e_lock = 1'b0; cyc = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; div_load = '0; sync = 1'b0;
    repeat (n) begin
      @(posedge clkin); #1;
      chk("rst_clk_out", clk_out, '0);
      chk("rst_clk_en", clk_en, '0);
      chk("rst_busy", div_busy, '0);
      chk("rst_lock", lock, 1'b0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [NCH-1:0] ld, input int v0, input int v1, input logic sy);
    int  vals[NCH];
    int  pos;
    bit  restart;
    chk("clk_out", clk_out, e_out);
    chk("clk_en", clk_en, e_en);
    chk("div_busy", div_busy, e_busy);
    chk("lock", lock, e_lock);
    div_load = ld; div_val = {v1[7:0], v0[7:0]}; sync = sy;
    vals[0] = v0; vals[1] = v1;
    restart = sy;
    for (int ch = 0; ch < NCH; ch++) begin
      pos = mpos(ch);
      e_out[ch] = (pos < m_d[ch] / 2);
      e_en[ch]  = (pos == m_d[ch] - 1);
      if (ld[ch]) begin
        m_p[ch] = (vals[ch] < 2) ? 2 : vals[ch];
        m_pend[ch] = 1;
      end
      if (sy) m_t0[ch] = cyc + 1;
      if ((sy || pos == m_d[ch] - 1) && m_pend[ch]) begin
        m_d[ch] = m_p[ch]; m_pend[ch] = 0; m_t0[ch] = cyc + 1; restart = 1;
      end
      e_busy[ch] = m_pend[ch];
    end
`ifdef CLK_DIV_LOCK_EN
    if (restart) m_ls = cyc + 1;
    e_lock = ((cyc + 1 - m_ls) >= LOCK_CYCLES);
`else
    e_lock = 1'b1;
`endif
    @(posedge clkin); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 0, 0, 1'b0);
  endtask

  initial begin
    int en_times[$];
    int s, ncoinc, prob_ld, prob_sy;
    logic [NCH-1:0] ld;

    do_reset(3);

    // Default divisor 4: clk_out 1,1,0,0 from cycle 1, clk_en on multiples of 4.
    repeat (21) begin
      chk("pat_out", clk_out[0], (cyc > 0 && ((cyc - 1) % 4) < 2));
      chk("pat_en", clk_en[0], (cyc > 0 && (cyc % 4) == 0));
`ifdef CLK_DIV_LOCK_EN
      chk("lock_rise", lock, (cyc >= 16));
`else
      chk("lock_const", lock, (cyc >= 1));
`endif
      step('0, 0, 0, 1'b0);
    end

    // Load 6 on ch0 at cnt=1 (cycle 21): busy in 22..23, gone by 24.
    step(2'b01, 6, 0, 1'b0);
    repeat (3) begin
      chk("busy_win", div_busy[0], (cyc < 24));
      step('0, 0, 0, 1'b0);
    end
    idle(20);

    // Zero on ch1 clamps to 2.
    step(2'b10, 0, 0, 1'b0);
    idle(12);

    // Load 5 then 7 before the boundary: periods of 7 only.
    for (int k = 0; k < 16 && mpos(0) != 0; k++) idle(1);
    step(2'b01, 5, 0, 1'b0);
    step(2'b01, 7, 0, 1'b0);
    en_times.delete();
    repeat (34) begin
      if (clk_en[0] === 1'b1) en_times.push_back(cyc);
      step('0, 0, 0, 1'b0);
    end
    chk("last_wins_n", (en_times.size() >= 4), 1'b1);
    for (int i = 1; i + 1 < en_times.size(); i++)
      chk("last_wins_per", en_times[i+1] - en_times[i], 7);

    // d=4 and d=6, sync mid-period: joint clk_en every 12 cycles.
    step(2'b11, 4, 6, 1'b0);
    idle(15);
    s = cyc;
    step('0, 0, 0, 1'b1);
    idle(1);
    chk("sync_out_high", clk_out, 2'b11);
    ncoinc = 0;
    repeat (40) begin
      if (clk_en === 2'b11) begin
        ncoinc++;
        chk("sync_coinc", (cyc - s - 1) % 12, 0);
      end
      step('0, 0, 0, 1'b0);
    end
    chk("sync_coinc_n", (ncoinc >= 3), 1'b1);

    // Random traffic alternating busy and quiet stretches.
    for (int blk = 0; blk < 16; blk++) begin
      prob_ld = (blk % 2) ? 60 : 6;
      prob_sy = (blk % 2) ? 300 : 40;
      repeat (100) begin
        for (int ch = 0; ch < NCH; ch++) ld[ch] = ($urandom_range(0, prob_ld - 1) == 0);
        step(ld, $urandom_range(0, 12), $urandom_range(0, 12),
             ($urandom_range(0, prob_sy - 1) == 0));
      end
    end

    // Reset mid-run, then settle again.
    idle(7);
    do_reset(2);
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
